// File: rtl/pic_sync_n.sv
// pic_sync_n: clocked 8259A-style interrupt controller, fully nested priority, two-pulse INTA vector.
// Define PIC_ROTATE_EN to enable rotate-on-non-specific-EOI (OCW2 code 101).
module pic_sync_n #(
    parameter int N_IRQ       = 8,
    parameter int IDX_W       = $clog2(N_IRQ),
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CS,
    input  logic             WR,
    input  logic             RD,
    input  logic             A0,
    inout  wire  [7:0]       D,
    input  logic [N_IRQ-1:0] IR,
    input  logic             INTA,
    output logic             INT
);
    typedef enum logic [2:0] {UNINIT, WAIT_ICW2, IDLE, ACK1, ACK2} state_t;

    state_t                           state_q;
    logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
    logic [N_IRQ-1:0]                 irr_q, isr_q, imr_q, irp_q;
    logic [7-IDX_W:0]                 base_q;
    logic [IDX_W-1:0]                 idx_q, ptr;
    logic                             ltim_q, rsel_q, wr_q, a0_q, inta_q, int_q;
    logic [7:0]                       d_q, dout;

    logic [N_IRQ-1:0] ir_s, irr_set, eoi_clr, ack_set;
    logic [IDX_W:0]   cand, svc;
    logic [IDX_W-1:0] cand_idx, svc_idx;
    logic cand_valid, wr_fire, icw1, ready, ocw1, ocw2, ocw3;
    logic eoi_ns, eoi_sp, eoi_rot, inta_fall, inta_rise, ack_start, int_d, vec_oe, rd_oe;

    // Returns {found, rank}; rank 0 is the highest priority, which sits just above ptr.
    function automatic logic [IDX_W:0] find_hi(input logic [N_IRQ-1:0] v, input logic [IDX_W-1:0] p);
        logic [IDX_W:0]   r;
        logic [IDX_W-1:0] j;
        r = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            j = p + IDX_W'(1) + IDX_W'(i);
            if (v[j]) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

`ifdef PIC_ROTATE_EN
    logic [IDX_W-1:0] ptr_q;
    assign ptr     = ptr_q;
    assign eoi_rot = ocw2 && d_q[7:5] == 3'b101;
`else
    assign ptr     = IDX_W'(N_IRQ - 1);
    assign eoi_rot = 1'b0;
`endif

    assign ir_s       = sync_q[SYNC_STAGES-1];
    assign irr_set    = ir_s & ~irp_q;
    assign cand       = find_hi(irr_q & ~imr_q, ptr);
    assign svc        = find_hi(isr_q, ptr);
    assign cand_idx   = ptr + IDX_W'(1) + cand[IDX_W-1:0];
    assign svc_idx    = ptr + IDX_W'(1) + svc[IDX_W-1:0];
    assign cand_valid = cand[IDX_W] && (!svc[IDX_W] || cand[IDX_W-1:0] < svc[IDX_W-1:0]);

    assign wr_fire   = !wr_q && WR && !CS;
    assign ready     = state_q == IDLE || state_q == ACK1 || state_q == ACK2;
    assign icw1      = wr_fire && !a0_q && d_q[4];
    assign ocw1      = wr_fire && a0_q && ready;
    assign ocw2      = wr_fire && !a0_q && d_q[4:3] == 2'b00 && ready;
    assign ocw3      = wr_fire && !a0_q && d_q[4:3] == 2'b01 && ready;
    assign eoi_ns    = ocw2 && d_q[7:5] == 3'b001;
    assign eoi_sp    = ocw2 && d_q[7:5] == 3'b011;
    assign inta_fall = inta_q && !INTA;
    assign inta_rise = !inta_q && INTA;
    assign ack_start = state_q == IDLE && inta_fall;
    assign int_d     = cand_valid && ((state_q == IDLE && !inta_fall) || (state_q == ACK2 && inta_rise));

    always_comb begin
        eoi_clr = '0;
        ack_set = '0;
        if ((eoi_ns || eoi_rot) && svc[IDX_W]) eoi_clr[svc_idx] = 1'b1;
        if (eoi_sp) eoi_clr[d_q[IDX_W-1:0]] = 1'b1;
        if (ack_start && cand_valid) ack_set[cand_idx] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= UNINIT;
            sync_q  <= '0;
            irr_q   <= '0;
            isr_q   <= '0;
            imr_q   <= '1;
            irp_q   <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            ltim_q  <= 1'b0;
            rsel_q  <= 1'b0;
            wr_q    <= 1'b1;
            a0_q    <= 1'b0;
            d_q     <= '0;
            inta_q  <= 1'b1;
            int_q   <= 1'b0;
`ifdef PIC_ROTATE_EN
            ptr_q   <= IDX_W'(N_IRQ - 1);
`endif
        end else begin
            wr_q   <= WR;
            a0_q   <= A0;
            d_q    <= D;
            inta_q <= INTA;
            sync_q <= {sync_q[SYNC_STAGES-2:0], IR};
            if (icw1) begin
                ltim_q  <= d_q[3];
                imr_q   <= '0;
                isr_q   <= '0;
                irr_q   <= '0;
                irp_q   <= '0;
                rsel_q  <= 1'b0;
                int_q   <= 1'b0;
                state_q <= WAIT_ICW2;
`ifdef PIC_ROTATE_EN
                ptr_q   <= IDX_W'(N_IRQ - 1);
`endif
            end else begin
                irp_q <= ir_s;
                irr_q <= ltim_q ? ir_s : ((irr_q | irr_set) & ~ack_set);
                isr_q <= (isr_q & ~eoi_clr) | ack_set;
                int_q <= int_d;
                if (ocw1) imr_q <= d_q[N_IRQ-1:0];
                if (ocw3 && d_q[1]) rsel_q <= d_q[0];
`ifdef PIC_ROTATE_EN
                if (eoi_rot && svc[IDX_W]) ptr_q <= svc_idx;
`endif
                case (state_q)
                    WAIT_ICW2: if (wr_fire && a0_q) begin
                        base_q  <= d_q[7:IDX_W];
                        state_q <= IDLE;
                    end
                    IDLE: if (inta_fall) begin
                        idx_q   <= cand_valid ? cand_idx : IDX_W'(N_IRQ - 1);
                        state_q <= ACK1;
                    end
                    ACK1:    if (inta_fall) state_q <= ACK2;
                    ACK2:    if (inta_rise) state_q <= IDLE;
                    default: ;
                endcase
            end
        end
    end

    // Vector drive yields to an active bus write so the master never fights the PIC.
    assign vec_oe = state_q == ACK2 && !INTA && !(!CS && !WR);
    assign rd_oe  = !CS && !RD && WR;

    always_comb begin
        dout = '0;
        if (vec_oe)      dout = {base_q, idx_q};
        else if (A0)     dout = 8'(imr_q);
        else if (rsel_q) dout = 8'(isr_q);
        else             dout = 8'(irr_q);
    end

    assign D   = (vec_oe || rd_oe) ? dout : 8'hzz;
    assign INT = int_q;
endmodule

// File: tb/tb_pic_sync_n.sv
// tb_pic_sync_n: directed scenarios for pic_sync_n (N_IRQ=8, SYNC_STAGES=2).
// A released D bus reads 0xFF through the bench pull-ups.
module tb_pic_sync_n;
    logic       CLK, RST, CS, WR, RD, A0, INTA, INT;
    logic [7:0] IR;
    wire  [7:0] D;
    logic [7:0] d_drv;
    logic       d_oe;
    int         nvec, nerr;

    assign D = d_oe ? d_drv : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (D[g]);
    end

    pic_sync_n #(.N_IRQ(8), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .CS(CS), .WR(WR), .RD(RD), .A0(A0),
        .D(D), .IR(IR), .INTA(INTA), .INT(INT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic ticks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic bus_wr(input logic a, input logic [7:0] v);
        @(negedge CLK);
        CS = 1'b0; A0 = a; d_drv = v; d_oe = 1'b1; WR = 1'b0;
        @(negedge CLK);
        WR = 1'b1; d_oe = 1'b0;
        @(negedge CLK);
        CS = 1'b1;
    endtask

    task automatic bus_rd(input logic a, output logic [7:0] v);
        @(negedge CLK);
        CS = 1'b0; RD = 1'b0; A0 = a;
        #1 v = D;
        CS = 1'b1; RD = 1'b1;
    endtask

    task automatic inta_pair(output logic [7:0] v1, output logic [7:0] v2);
        @(negedge CLK); INTA = 1'b0;
        @(negedge CLK); v1 = D; INTA = 1'b1;
        @(negedge CLK); INTA = 1'b0;
        @(negedge CLK); v2 = D; INTA = 1'b1;
        @(negedge CLK);
    endtask

    task automatic pulse_ir(input logic [7:0] m);
        @(negedge CLK); IR = m;
        ticks(5);
        IR = '0;
    endtask

    task automatic test_reset();
        logic [7:0] r;
        ticks(2);
        nvec++; if (INT !== 1'b0) begin nerr++; $display("FAIL rst_int: got %b want 0", INT); end
        nvec++; if (D !== 8'hFF) begin nerr++; $display("FAIL rst_bus_released: got %h want ff", D); end
        @(negedge CLK); RST = 1'b1;
        bus_rd(1'b1, r);
        nvec++; if (r !== 8'hFF) begin nerr++; $display("FAIL rst_imr: got %h want ff", r); end
        bus_rd(1'b0, r);
        nvec++; if (r !== 8'h00) begin nerr++; $display("FAIL rst_irr: got %h want 00", r); end
    endtask

    task automatic test_init();
        logic [7:0] v1, v2, r;
        bus_wr(1'b0, 8'h13);
        bus_wr(1'b1, 8'hA8);
        bus_wr(1'b1, 8'h00);
        @(negedge CLK); IR = 8'h08;
        ticks(3);
        nvec++; if (INT !== 1'b0) begin nerr++; $display("FAIL init_int_early: got %b want 0", INT); end
        ticks(1);
        nvec++; if (INT !== 1'b1) begin nerr++; $display("FAIL init_int_latency: got %b want 1", INT); end
        IR = '0;
        inta_pair(v1, v2);
        nvec++; if (v1 !== 8'hFF) begin nerr++; $display("FAIL init_ack1_bus: got %h want ff", v1); end
        nvec++; if (v2 !== 8'hAB) begin nerr++; $display("FAIL init_vector: got %h want ab", v2); end
        nvec++; if (INT !== 1'b0) begin nerr++; $display("FAIL init_int_after_ack: got %b want 0", INT); end
        bus_wr(1'b0, 8'h0B);
        bus_rd(1'b0, r);
        nvec++; if (r !== 8'h08) begin nerr++; $display("FAIL init_isr: got %h want 08", r); end
        bus_wr(1'b0, 8'h0A);
        bus_rd(1'b0, r);
        nvec++; if (r !== 8'h00) begin nerr++; $display("FAIL init_irr_cleared: got %h want 00", r); end
        bus_wr(1'b0, 8'h20);
    endtask

    task automatic test_priority();
        logic [7:0] v1, v2;
        pulse_ir(8'h24);
        nvec++; if (INT !== 1'b1) begin nerr++; $display("FAIL prio_int: got %b want 1", INT); end
        inta_pair(v1, v2);
        nvec++; if (v2 !== 8'hAA) begin nerr++; $display("FAIL prio_first_vec: got %h want aa", v2); end
        ticks(1);
        nvec++; if (INT !== 1'b0) begin nerr++; $display("FAIL prio_nested_block: got %b want 0", INT); end
        bus_wr(1'b0, 8'h20);
        ticks(2);
        nvec++; if (INT !== 1'b1) begin nerr++; $display("FAIL prio_reassert: got %b want 1", INT); end
        inta_pair(v1, v2);
        nvec++; if (v2 !== 8'hAD) begin nerr++; $display("FAIL prio_second_vec: got %h want ad", v2); end
        bus_wr(1'b0, 8'h20);
    endtask

    task automatic test_nest_mask();
        logic [7:0] v1, v2, r;
        pulse_ir(8'h04);
        inta_pair(v1, v2);
        nvec++; if (v2 !== 8'hAA) begin nerr++; $display("FAIL nest_vec2: got %h want aa", v2); end
        pulse_ir(8'h40);
        nvec++; if (INT !== 1'b0) begin nerr++; $display("FAIL nest_lower_blocked: got %b want 0", INT); end
        pulse_ir(8'h02);
        nvec++; if (INT !== 1'b1) begin nerr++; $display("FAIL nest_higher_int: got %b want 1", INT); end
        bus_wr(1'b1, 8'h02);
        ticks(2);
        nvec++; if (INT !== 1'b0) begin nerr++; $display("FAIL mask_int: got %b want 0", INT); end
        bus_wr(1'b1, 8'h00);
        ticks(2);
        nvec++; if (INT !== 1'b1) begin nerr++; $display("FAIL unmask_int: got %b want 1", INT); end
        inta_pair(v1, v2);
        nvec++; if (v2 !== 8'hA9) begin nerr++; $display("FAIL nest_vec1: got %h want a9", v2); end
        bus_wr(1'b0, 8'h61);
        ticks(2);
        nvec++; if (INT !== 1'b0) begin nerr++; $display("FAIL spec_eoi1_int: got %b want 0", INT); end
        bus_wr(1'b0, 8'h62);
        ticks(2);
        nvec++; if (INT !== 1'b1) begin nerr++; $display("FAIL spec_eoi2_int: got %b want 1", INT); end
        inta_pair(v1, v2);
        nvec++; if (v2 !== 8'hAE) begin nerr++; $display("FAIL nest_vec6: got %h want ae", v2); end
        bus_wr(1'b0, 8'h66);
        bus_wr(1'b0, 8'h0B);
        bus_rd(1'b0, r);
        nvec++; if (r !== 8'h00) begin nerr++; $display("FAIL nest_isr_empty: got %h want 00", r); end
        bus_wr(1'b0, 8'h0A);
    endtask

    task automatic test_ocw2_code();
        logic [7:0] v1, v2, r;
        pulse_ir(8'h04);
        inta_pair(v1, v2);
        nvec++; if (v2 !== 8'hAA) begin nerr++; $display("FAIL code5_setup_vec: got %h want aa", v2); end
        bus_wr(1'b0, 8'hA0);
        bus_wr(1'b0, 8'h0B);
        bus_rd(1'b0, r);
`ifdef PIC_ROTATE_EN
        nvec++; if (r !== 8'h00) begin nerr++; $display("FAIL rot_isr_clear: got %h want 00", r); end
        pulse_ir(8'h0C);
        inta_pair(v1, v2);
        nvec++; if (v2 !== 8'hAB) begin nerr++; $display("FAIL rot_first_vec: got %h want ab", v2); end
        bus_wr(1'b0, 8'h20);
        ticks(2);
        inta_pair(v1, v2);
        nvec++; if (v2 !== 8'hAA) begin nerr++; $display("FAIL rot_second_vec: got %h want aa", v2); end
`else
        nvec++; if (r !== 8'h04) begin nerr++; $display("FAIL code5_ignored: got %h want 04", r); end
`endif
        bus_wr(1'b0, 8'h20);
        bus_wr(1'b0, 8'h0A);
    endtask

    task automatic test_level();
        logic [7:0] v1, v2, r;
        bus_wr(1'b0, 8'h1B);
        bus_wr(1'b1, 8'hA8);
        bus_wr(1'b1, 8'h00);
        @(negedge CLK); IR = 8'h10;
        ticks(5);
        nvec++; if (INT !== 1'b1) begin nerr++; $display("FAIL lvl_int: got %b want 1", INT); end
        inta_pair(v1, v2);
        nvec++; if (v2 !== 8'hAC) begin nerr++; $display("FAIL lvl_vec: got %h want ac", v2); end
        ticks(1);
        nvec++; if (INT !== 1'b0) begin nerr++; $display("FAIL lvl_in_service: got %b want 0", INT); end
        bus_wr(1'b0, 8'h64);
        ticks(2);
        nvec++; if (INT !== 1'b1) begin nerr++; $display("FAIL lvl_reassert: got %b want 1", INT); end
        IR = '0;
        ticks(5);
        nvec++; if (INT !== 1'b0) begin nerr++; $display("FAIL lvl_drop_int: got %b want 0", INT); end
        inta_pair(v1, v2);
        nvec++; if (v2 !== 8'hAF) begin nerr++; $display("FAIL lvl_spurious_vec: got %h want af", v2); end
        bus_wr(1'b0, 8'h0B);
        bus_rd(1'b0, r);
        nvec++; if (r !== 8'h00) begin nerr++; $display("FAIL lvl_spurious_isr: got %h want 00", r); end
    endtask

    task automatic test_abort();
        logic [7:0] v1, v2, r;
        @(negedge CLK); IR = 8'h10;
        ticks(5);
        @(negedge CLK); INTA = 1'b0;
        @(negedge CLK); INTA = 1'b1;
        #2 RST = 1'b0;
        #1;
        nvec++; if (INT !== 1'b0) begin nerr++; $display("FAIL abort_rst_int: got %b want 0", INT); end
        nvec++; if (D !== 8'hFF) begin nerr++; $display("FAIL abort_rst_bus: got %h want ff", D); end
        IR = '0;
        bus_rd(1'b1, r);
        nvec++; if (r !== 8'hFF) begin nerr++; $display("FAIL abort_rst_imr: got %h want ff", r); end
        @(negedge CLK); RST = 1'b1;
        bus_wr(1'b0, 8'h13);
        bus_wr(1'b1, 8'hA8);
        bus_wr(1'b1, 8'h00);
        @(negedge CLK); INTA = 1'b0;
        @(negedge CLK); INTA = 1'b1;
        @(negedge CLK); INTA = 1'b0;
        @(negedge CLK);
        nvec++; if (D !== 8'hAF) begin nerr++; $display("FAIL abort_ack2_vec: got %h want af", D); end
        bus_wr(1'b0, 8'h13);
        nvec++; if (D !== 8'hFF) begin nerr++; $display("FAIL abort_icw1_release: got %h want ff", D); end
        nvec++; if (INT !== 1'b0) begin nerr++; $display("FAIL abort_icw1_int: got %b want 0", INT); end
        INTA = 1'b1;
        ticks(2);
        bus_wr(1'b1, 8'hB0);
        bus_rd(1'b1, r);
        nvec++; if (r !== 8'h00) begin nerr++; $display("FAIL abort_wait_icw2: imr got %h want 00", r); end
        inta_pair(v1, v2);
        nvec++; if (v2 !== 8'hB7) begin nerr++; $display("FAIL abort_new_base: got %h want b7", v2); end
    endtask

    initial begin
        nvec = 0; nerr = 0;
        RST = 1'b0; CS = 1'b1; WR = 1'b1; RD = 1'b1; A0 = 1'b0; INTA = 1'b1;
        IR = '0; d_drv = '0; d_oe = 1'b0;
        test_reset();
        test_init();
        test_priority();
        test_nest_mask();
        test_ocw2_code();
        test_level();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
